eyeriss_glb_multicast: RTL and testbench

- Upstream feeder for a row of Eyeriss PEs.
- Takes a tagged word stream from the global buffer (GLB): data, destination ID and type.
- Buffers the stream in a small FIFO and drives the PE-shared bus: a 16-bit data word, an 8-bit id, and one-hot getdata_fil / getdata_map / getdata_psum strobes.
- Each PE latches the word only when the id matches its configured id.
- One transfer job of a configured word count runs per start pulse. A done pulse and an error count are reported at the end of the job.

---
 rtl/eyeriss_glb_multicast.sv | 185 ++++++++++++++++++
 tb/tb_eyeriss_glb_multicast.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/eyeriss_glb_multicast.sv
// GLB-to-PE multicast feeder: buffers tagged GLB words and issues them on the
// shared PE bus with a one-hot type strobe, one job of cfg_words words per start.
module eyeriss_glb_multicast #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 12
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_words,
    input  logic             glb_valid,
    input  logic [15:0]      glb_data,
    input  logic [7:0]       glb_id,
    input  logic [1:0]       glb_type,
    output logic             glb_ready,
    input  logic             stall,
    output logic [15:0]      data_o,
    output logic [7:0]       id_o,
    output logic             getdata_fil,
    output logic             getdata_map,
    output logic             getdata_psum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] cfg_words_q, cfg_words_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [15:0]      data_q;
    logic [7:0]       id_q;
    logic             fil_q, map_q, psum_q;

    logic             full_s, empty_s, ready_s, accept_s, push_s, pop_s;
    logic [CNT_W-1:0] acc_inc_s;
    logic [EW-1:0]    head_s;

    // FIFO flags, handshake qualifiers and the head entry.
    always_comb begin
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_s   = (wr_ptr_q == rd_ptr_q);
        ready_s   = (state_q == RUN) && !full_s && (acc_cnt_q < cfg_words_q);
        accept_s  = glb_valid && ready_s;
        push_s    = accept_s && (glb_type != 2'd3);
        pop_s     = !empty_s && !stall;
        acc_inc_s = acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        head_s    = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Job sequencing and word/error counters; illegal words are consumed but counted as errors.
    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        cfg_words_d = cfg_words_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    cfg_words_d = cfg_words;
                    if (cfg_words != {CNT_W{1'b0}}) begin
                        state_d   = RUN;
                        acc_cnt_d = {CNT_W{1'b0}};
                        err_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    acc_cnt_d = acc_inc_s;
                    if (glb_type == 2'd3 && err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if (acc_inc_s == cfg_words_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (empty_s) begin
                    state_d = FIN;
                end else begin
                    state_d = DRAIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            acc_cnt_q   <= {CNT_W{1'b0}};
            cfg_words_q <= {CNT_W{1'b0}};
            err_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            cfg_words_q <= cfg_words_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {glb_type, glb_id, glb_data};
        end
    end

    // FIFO pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Issue stage: a popped entry becomes one bus beat; data/id hold between beats.
    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            data_q <= 16'h0000;
            id_q   <= 8'h00;
            fil_q  <= 1'b0;
            map_q  <= 1'b0;
            psum_q <= 1'b0;
        end else if (pop_s) begin
            data_q <= head_s[15:0];
            id_q   <= head_s[23:16];
            case (head_s[25:24])
                2'd0: begin fil_q <= 1'b1; map_q <= 1'b0; psum_q <= 1'b0; end
                2'd1: begin fil_q <= 1'b0; map_q <= 1'b1; psum_q <= 1'b0; end
                2'd2: begin fil_q <= 1'b0; map_q <= 1'b0; psum_q <= 1'b1; end
                default: begin fil_q <= 1'b0; map_q <= 1'b0; psum_q <= 1'b0; end
            endcase
        end else begin
            fil_q  <= 1'b0;
            map_q  <= 1'b0;
            psum_q <= 1'b0;
        end
    end

    assign glb_ready    = ready_s;
    assign data_o       = data_q;
    assign id_o         = id_q;
    assign getdata_fil  = fil_q;
    assign getdata_map  = map_q;
    assign getdata_psum = psum_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_eyeriss_glb_multicast.sv
// Directed bench for eyeriss_glb_multicast: hand-computed bus beats, flow
// control under stall, illegal-word dropping, empty jobs and mid-job reset.
module tb_eyeriss_glb_multicast;

    logic        CLK = 1'b0;
    logic        clr;
    logic        cfg_start;
    logic [11:0] cfg_words;
    logic        glb_valid;
    logic [15:0] glb_data;
    logic [7:0]  glb_id;
    logic [1:0]  glb_type;
    logic        glb_ready;
    logic        stall;
    logic [15:0] data_o;
    logic [7:0]  id_o;
    logic        getdata_fil, getdata_map, getdata_psum;
    logic        busy, done;
    logic [11:0] err_cnt;
    logic [2:0]  strb;

    int tests = 0;
    int fails = 0;

    eyeriss_glb_multicast dut (
        .CLK(CLK), .clr(clr), .cfg_start(cfg_start), .cfg_words(cfg_words),
        .glb_valid(glb_valid), .glb_data(glb_data), .glb_id(glb_id),
        .glb_type(glb_type), .glb_ready(glb_ready), .stall(stall),
        .data_o(data_o), .id_o(id_o), .getdata_fil(getdata_fil),
        .getdata_map(getdata_map), .getdata_psum(getdata_psum),
        .busy(busy), .done(done), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;
    assign strb = {getdata_fil, getdata_map, getdata_psum};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [7:0] id, input logic [15:0] d);
        glb_valid = v;
        glb_type  = t;
        glb_id    = id;
        glb_data  = d;
    endtask

    task automatic beat(input string tag, input logic [2:0] s, input logic [7:0] id, input logic [15:0] d);
        check({tag, "_strb"}, {29'd0, strb}, {29'd0, s});
        check({tag, "_id"}, {24'd0, id_o}, {24'd0, id});
        check({tag, "_data"}, {16'd0, data_o}, {16'd0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, nd;
        logic [15:0] last_d;
        clr = 1'b0; cfg_start = 1'b0; cfg_words = 12'd0; stall = 1'b0;
        drive(1'b0, 2'd0, 8'd0, 16'd0);
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, glb_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        beat("rst", 3'b000, 8'h00, 16'h0000);
        check("rst_err", {20'd0, err_cnt}, 32'd0);
        tick(); tick();
        clr = 1'b1;
        tick();

        // Three words, one of each type, no stall.
        cfg_start = 1'b1; cfg_words = 12'd3;
        tick();
        cfg_start = 1'b0;
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready", {31'd0, glb_ready}, 32'd1);
        drive(1'b1, 2'd0, 8'd5, 16'h1111);
        tick();
        check("t1_nostrb", {29'd0, strb}, 32'd0);
        drive(1'b1, 2'd1, 8'd5, 16'h2222);
        tick();
        beat("t1_fil", 3'b100, 8'd5, 16'h1111);
        drive(1'b1, 2'd2, 8'd7, 16'h3333);
        tick();
        beat("t1_map", 3'b010, 8'd5, 16'h2222);
        check("t1_ready_off", {31'd0, glb_ready}, 32'd0);
        drive(1'b0, 2'd0, 8'd0, 16'd0);
        tick();
        beat("t1_psum", 3'b001, 8'd7, 16'h3333);
        check("t1_notdone", {31'd0, done}, 32'd0);
        tick();
        check("t1_done", {31'd0, done}, 32'd1);
        beat("t1_hold", 3'b000, 8'd7, 16'h3333);
        tick();
        check("t1_done_once", {31'd0, done}, 32'd0);
        check("t1_idle", {31'd0, busy}, 32'd0);
        check("t1_err", {20'd0, err_cnt}, 32'd0);

        // Fill the FIFO under stall, then release; job of 5 exercises the full flag.
        stall = 1'b1;
        cfg_start = 1'b1; cfg_words = 12'd5;
        tick();
        cfg_start = 1'b0;
        drive(1'b1, 2'd0, 8'd1, 16'h0A01); tick();
        drive(1'b1, 2'd1, 8'd2, 16'h0A02); tick();
        drive(1'b1, 2'd2, 8'd3, 16'h0A03); tick();
        check("t2_ready_3", {31'd0, glb_ready}, 32'd1);
        drive(1'b1, 2'd0, 8'd4, 16'h0A04); tick();
        drive(1'b0, 2'd0, 8'd0, 16'd0);
        check("t2_full_ready", {31'd0, glb_ready}, 32'd0);
        check("t2_stall_strb", {29'd0, strb}, 32'd0);
        tick(); tick();
        check("t2_stall_strb2", {29'd0, strb}, 32'd0);
        check("t2_stall_busy", {31'd0, busy}, 32'd1);
        stall = 1'b0;
        drive(1'b1, 2'd1, 8'd5, 16'h0A05);
        check("t2_pop_noroom", {31'd0, glb_ready}, 32'd0);
        tick();
        beat("t2_w0", 3'b100, 8'd1, 16'h0A01);
        check("t2_room", {31'd0, glb_ready}, 32'd1);
        tick();
        drive(1'b0, 2'd0, 8'd0, 16'd0);
        beat("t2_w1", 3'b010, 8'd2, 16'h0A02);
        check("t2_drain_ready", {31'd0, glb_ready}, 32'd0);
        tick(); beat("t2_w2", 3'b001, 8'd3, 16'h0A03);
        tick(); beat("t2_w3", 3'b100, 8'd4, 16'h0A04);
        tick(); beat("t2_w4", 3'b010, 8'd5, 16'h0A05);
        check("t2_notdone", {31'd0, done}, 32'd0);
        tick();
        check("t2_done", {31'd0, done}, 32'd1);
        tick();

        // Four words with an illegal second word.
        cfg_start = 1'b1; cfg_words = 12'd4;
        tick();
        cfg_start = 1'b0;
        drive(1'b1, 2'd1, 8'd9, 16'hA0A0); tick();
        drive(1'b1, 2'd3, 8'd9, 16'hDEAD); tick();
        beat("t3_x0", 3'b010, 8'd9, 16'hA0A0);
        drive(1'b1, 2'd2, 8'd10, 16'hB0B0); tick();
        check("t3_err", {20'd0, err_cnt}, 32'd1);
        beat("t3_gap", 3'b000, 8'd9, 16'hA0A0);
        drive(1'b1, 2'd0, 8'd11, 16'hC0C0); tick();
        drive(1'b0, 2'd0, 8'd0, 16'd0);
        beat("t3_x2", 3'b001, 8'd10, 16'hB0B0);
        tick();
        beat("t3_x3", 3'b100, 8'd11, 16'hC0C0);
        tick();
        check("t3_done", {31'd0, done}, 32'd1);
        tick();
        check("t3_err_keep", {20'd0, err_cnt}, 32'd1);

        // Empty job.
        cfg_start = 1'b1; cfg_words = 12'd0;
        check("t4_ready_idle", {31'd0, glb_ready}, 32'd0);
        tick();
        cfg_start = 1'b0;
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_ready", {31'd0, glb_ready}, 32'd0);
        tick();
        check("t4_done_end", {31'd0, done}, 32'd0);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset with two words buffered.
        stall = 1'b1;
        cfg_start = 1'b1; cfg_words = 12'd4;
        tick();
        cfg_start = 1'b0;
        drive(1'b1, 2'd0, 8'd1, 16'h7777); tick();
        drive(1'b1, 2'd3, 8'd1, 16'h8888); tick();
        drive(1'b1, 2'd1, 8'd1, 16'h9999); tick();
        drive(1'b0, 2'd0, 8'd0, 16'd0);
        check("t5_err_pre", {20'd0, err_cnt}, 32'd1);
        #2 clr = 1'b0;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_ready", {31'd0, glb_ready}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_err", {20'd0, err_cnt}, 32'd0);
        beat("t5_bus", 3'b000, 8'h00, 16'h0000);
        tick();
        clr = 1'b1; stall = 1'b0;
        ns = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (strb != 3'b000) ns++;
        end
        check("t5_stale", ns, 32'd0);
        cfg_start = 1'b1; cfg_words = 12'd1;
        tick();
        cfg_start = 1'b0;
        drive(1'b1, 2'd2, 8'd3, 16'h5555); tick();
        drive(1'b0, 2'd0, 8'd0, 16'd0);
        ns = 0; nd = 0; last_d = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (strb != 3'b000) begin ns++; last_d = data_o; end
            if (done) nd++;
        end
        check("t5_one_strb", ns, 32'd1);
        check("t5_one_done", nd, 32'd1);
        check("t5_data", {16'd0, last_d}, 32'h5555);

        // cfg_start during RUN is ignored.
        cfg_start = 1'b1; cfg_words = 12'd2;
        tick();
        cfg_start = 1'b1; cfg_words = 12'd5;
        drive(1'b1, 2'd0, 8'd2, 16'h1234); tick();
        cfg_start = 1'b0; cfg_words = 12'd0;
        drive(1'b1, 2'd2, 8'd2, 16'h4321); tick();
        drive(1'b0, 2'd0, 8'd0, 16'd0);
        beat("t6_y0", 3'b100, 8'd2, 16'h1234);
        check("t6_ready_off", {31'd0, glb_ready}, 32'd0);
        tick();
        beat("t6_y1", 3'b001, 8'd2, 16'h4321);
        tick();
        check("t6_done", {31'd0, done}, 32'd1);
        tick();
        check("t6_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
